// File: rtl/wb_grf_trace.sv
// Write-back register file (32 x 32, r0 hard-wired to zero) with a 4-entry commit trace FIFO.
// Optional macro GRF_BYPASS_EN forwards same-cycle write-back data onto the read ports.
module wb_grf_trace (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [4:0]  RegAddrW,
  input  logic [31:0] RegDataW,
  input  logic [31:0] pcW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data,
  output logic [7:0]  trace_drop
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } trace_entry_t;

  logic [31:0]  regs_q [32];
  logic [31:0]  regs_d [32];
  trace_entry_t fifo_q [4];
  trace_entry_t fifo_d [4];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]   count_q, count_d;
  logic [7:0]   drop_q, drop_d;

  logic commit, full, empty, push, pop, drop;
  trace_entry_t head;

  always_comb begin
    // Commits seen while reset is held are ignored, including for forwarding.
    commit = RegWriteW && (RegAddrW != 5'd0) && reset;
    full   = (count_q == 3'd4);
    empty  = (count_q == 3'd0);
    pop    = !empty && trace_ready;
    push   = commit && (!full || pop);
    drop   = commit && full && !pop;

    regs_d = regs_q;
    if (commit) regs_d[RegAddrW] = RegDataW;

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = '{pc: pcW, addr: RegAddrW, data: RegDataW};

    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    count_d  = count_q + 3'(push) - 3'(pop);

    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: FIFO storage is deliberately left unreset; an empty FIFO masks its contents,
  // whereas the register array must be cleared because its contents are architecturally visible.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_comb begin
    RD1 = (A1 == 5'd0) ? 32'd0 : regs_q[A1];
    RD2 = (A2 == 5'd0) ? 32'd0 : regs_q[A2];
`ifdef GRF_BYPASS_EN
    if (commit && (A1 == RegAddrW)) RD1 = RegDataW;
    if (commit && (A2 == RegAddrW)) RD2 = RegDataW;
`endif
  end

  always_comb begin
    head        = fifo_q[rd_ptr_q];
    trace_valid = !empty;
    trace_pc    = empty ? 32'd0 : head.pc;
    trace_addr  = empty ? 5'd0  : head.addr;
    trace_data  = empty ? 32'd0 : head.data;
    trace_drop  = drop_q;
  end

endmodule

// File: tb/tb_wb_grf_trace.sv
// Directed self-checking bench for wb_grf_trace: register file, forwarding, trace FIFO, drop counter, reset.
module tb_wb_grf_trace;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [4:0]  RegAddrW;
  logic [31:0] RegDataW;
  logic [31:0] pcW;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [7:0]  trace_drop;

  int checks = 0;
  int errors = 0;

  wb_grf_trace dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteW  (RegWriteW),
    .RegAddrW   (RegAddrW),
    .RegDataW   (RegDataW),
    .pcW        (pcW),
    .A1         (A1),
    .A2         (A2),
    .RD1        (RD1),
    .RD2        (RD2),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_pc   (trace_pc),
    .trace_addr (trace_addr),
    .trace_data (trace_data),
    .trace_drop (trace_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    RegWriteW = 1'b1;
    RegAddrW  = a;
    RegDataW  = d;
    pcW       = pc;
    step();
    RegWriteW = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; RegWriteW = 1'b0; RegAddrW = '0; RegDataW = '0; pcW = '0;
    A1 = 5'd3; A2 = 5'd31; trace_ready = 1'b0;
    #1;
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
    checks++; if (trace_drop !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", trace_drop); end
    checks++; if (trace_pc !== 32'd0 || trace_addr !== 5'd0 || trace_data !== 32'd0) begin
      errors++; $display("FAIL reset_head: got pc=%h addr=%0d data=%h want zeros", trace_pc, trace_addr, trace_data);
    end
    step();
    step();
    checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h %h want 0 0", RD1, RD2); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    trace_ready = 1'b1;
    A1 = 5'd5; A2 = 5'd5;
    RegWriteW = 1'b1; RegAddrW = 5'd5; RegDataW = 32'h1234_5678; pcW = 32'h0000_0100;
    #1;
`ifdef GRF_BYPASS_EN
    checks++; if (RD1 !== 32'h1234_5678) begin errors++; $display("FAIL bypass_pre_rd1: got %h want 12345678", RD1); end
    checks++; if (RD2 !== 32'h1234_5678) begin errors++; $display("FAIL bypass_pre_rd2: got %h want 12345678", RD2); end
`else
    checks++; if (RD1 !== 32'd0) begin errors++; $display("FAIL bypass_pre_rd1: got %h want 0", RD1); end
    checks++; if (RD2 !== 32'd0) begin errors++; $display("FAIL bypass_pre_rd2: got %h want 0", RD2); end
`endif
    step();
    RegWriteW = 1'b0;
    #1;
    checks++; if (RD1 !== 32'h1234_5678) begin errors++; $display("FAIL bypass_post_rd1: got %h want 12345678", RD1); end
    checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h100 || trace_addr !== 5'd5 || trace_data !== 32'h1234_5678) begin
      errors++; $display("FAIL bypass_trace: got v=%b pc=%h addr=%0d data=%h want 1 100 5 12345678", trace_valid, trace_pc, trace_addr, trace_data);
    end
    step();
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL bypass_pop: got valid=%b want 0", trace_valid); end
  endtask

  task automatic test_reg0();
    trace_ready = 1'b0;
    A1 = 5'd0; A2 = 5'd3;
    RegWriteW = 1'b1; RegAddrW = 5'd0; RegDataW = 32'hFFFF_FFFF; pcW = 32'h0000_0200;
    #1;
    checks++; if (RD1 !== 32'd0) begin errors++; $display("FAIL reg0_pre: got %h want 0", RD1); end
    step();
    checks++; if (RD1 !== 32'd0) begin errors++; $display("FAIL reg0_rd: got %h want 0", RD1); end
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reg0_valid: got %b want 0", trace_valid); end
    checks++; if (trace_drop !== 8'd0) begin errors++; $display("FAIL reg0_drop: got %0d want 0", trace_drop); end
    // Write-enable low must not touch the array or the FIFO either.
    RegWriteW = 1'b0; RegAddrW = 5'd3; RegDataW = 32'hDEAD_BEEF;
    step();
    checks++; if (RD2 !== 32'd0 || trace_valid !== 1'b0) begin
      errors++; $display("FAIL nowrite: got rd=%h valid=%b want 0 0", RD2, trace_valid);
    end
  endtask

  task automatic test_overflow();
    trace_ready = 1'b0;
    for (int i = 1; i <= 6; i++) commit(5'(i), 32'h1000 + 32'(i), 32'h200 + 32'(4 * i));
    checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", trace_valid); end
    checks++; if (trace_drop !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", trace_drop); end
    A1 = 5'd6; #1;
    checks++; if (RD1 !== 32'h1006) begin errors++; $display("FAIL ovf_array: got %h want 1006", RD1); end
    trace_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (trace_addr !== 5'(i) || trace_data !== 32'h1000 + 32'(i) || trace_pc !== 32'h200 + 32'(4 * i)) begin
        errors++; $display("FAIL ovf_head%0d: got addr=%0d data=%h pc=%h", i, trace_addr, trace_data, trace_pc);
      end
      step();
    end
    checks++; if (trace_valid !== 1'b0 || trace_pc !== 32'd0) begin
      errors++; $display("FAIL ovf_empty: got valid=%b pc=%h want 0 0", trace_valid, trace_pc);
    end
  endtask

  task automatic test_full_push_pop();
    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr = '{5'd2, 5'd3, 5'd4, 5'd7};
    exp_data = '{32'h2002, 32'h2003, 32'h2004, 32'h7777_7777};
    trace_ready = 1'b0;
    for (int i = 1; i <= 4; i++) commit(5'(i), 32'h2000 + 32'(i), 32'h300 + 32'(4 * i));
    trace_ready = 1'b1;
    RegWriteW = 1'b1; RegAddrW = 5'd7; RegDataW = 32'h7777_7777; pcW = 32'h0000_03F0;
    step();
    RegWriteW = 1'b0; trace_ready = 1'b0;
    #1;
    checks++; if (trace_drop !== 8'd2) begin errors++; $display("FAIL fpp_drop: got %0d want 2", trace_drop); end
    trace_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== exp_addr[i] || trace_data !== exp_data[i]) begin
        errors++; $display("FAIL fpp_head%0d: got v=%b addr=%0d data=%h want addr=%0d data=%h",
                           i, trace_valid, trace_addr, trace_data, exp_addr[i], exp_data[i]);
      end
      step();
    end
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", trace_valid); end
  endtask

  task automatic test_reset_mid();
    trace_ready = 1'b0;
    commit(5'd9,  32'hA5A5_A5A5, 32'h400);
    commit(5'd10, 32'h0000_0010, 32'h404);
    commit(5'd11, 32'h0000_0011, 32'h408);
    A1 = 5'd9; A2 = 5'd12;
    #1;
    checks++; if (RD1 !== 32'hA5A5_A5A5 || trace_drop !== 8'd2 || trace_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: got rd=%h drop=%0d v=%b want a5a5a5a5 2 1", RD1, trace_drop, trace_valid);
    end
    RegWriteW = 1'b1; RegAddrW = 5'd12; RegDataW = 32'hDEAD_0012; pcW = 32'h500;
    trace_ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (trace_valid !== 1'b0 || trace_drop !== 8'd0 || RD1 !== 32'd0 || trace_pc !== 32'd0) begin
      errors++; $display("FAIL rmid_async: got v=%b drop=%0d rd=%h pc=%h want 0 0 0 0", trace_valid, trace_drop, RD1, trace_pc);
    end
    step();
    checks++; if (trace_valid !== 1'b0 || RD2 !== 32'd0) begin
      errors++; $display("FAIL rmid_held: got v=%b rd2=%h want 0 0", trace_valid, RD2);
    end
    RegWriteW = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rmid_release: got %b want 0", trace_valid); end
    trace_ready = 1'b0;
    commit(5'd13, 32'h0000_1313, 32'h600);
    checks++; if (trace_valid !== 1'b1 || trace_addr !== 5'd13 || trace_data !== 32'h1313 || trace_pc !== 32'h600) begin
      errors++; $display("FAIL rmid_resume: got v=%b addr=%0d data=%h pc=%h want 1 13 1313 600", trace_valid, trace_addr, trace_data, trace_pc);
    end
    trace_ready = 1'b1;
    step();
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain: got %b want 0", trace_valid); end
  endtask

  task automatic test_saturation();
    trace_ready = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      commit(5'((n % 31) + 1), 32'(n), 32'(4 * n));
      if (n == 258) begin
        checks++; if (trace_drop !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", trace_drop); end
      end
      if (n == 259) begin
        checks++; if (trace_drop !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", trace_drop); end
      end
    end
    checks++; if (trace_drop !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", trace_drop); end
    checks++; if (trace_valid !== 1'b1 || trace_data !== 32'd1 || trace_addr !== 5'd2) begin
      errors++; $display("FAIL sat_head: got v=%b addr=%0d data=%h want 1 2 1", trace_valid, trace_addr, trace_data);
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (trace_valid !== 1'b0 || trace_drop !== 8'd255) begin
      errors++; $display("FAIL sat_drain: got v=%b drop=%0d want 0 255", trace_valid, trace_drop);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_reg0();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
